// File: rtl/uart_pkg.sv
// uart_pkg: CTRL bit indices, oversampling constants and FSM state types for uart_reg_core
package uart_pkg;
  localparam int CTRL_EN        = 0;
  localparam int CTRL_TX_PEND   = 1;
  localparam int CTRL_TX_BUSY   = 2;
  localparam int CTRL_RX_VALID  = 3;
  localparam int CTRL_LOOPBACK  = 4;
  localparam int CTRL_FRAME_ERR = 5;
  localparam int CTRL_OVERRUN   = 6;
  localparam int OVERSAMPLE     = 16;
  localparam int MID_SAMPLE     = 7;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running BAUD_DIV counter producing a 1-cycle oversample tick
module uart_baud_tick #(
  parameter logic [15:0] BAUD_DIV = 16'd2
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == BAUD_DIV - 16'd1;
  always_ff @(posedge Clk)
    cnt <= (Rst || tick) ? 16'd0 : cnt + 16'd1;
endmodule

// File: rtl/uart_reg_core.sv
// uart_reg_core: register-mapped 8N1 UART (tick generator, TX, RX, CTRL/DATA registers)
// Optional feature: define UART_LOOPBACK_EN to make CTRL[4] route internal Tx into the receiver.
module uart_reg_core
  import uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd2,
  parameter int          NBITS    = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rx,
  output logic        Tx,
  input  logic        reg_sel_i,
  input  logic        wr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [2:0] LAST_BIT  = 3'(NBITS - 1);

  logic tick, en, tx_pend, tx_busy, rx_valid, frame_err, overrun, loopback;
  logic rx_s1, rx_s2, rx_in, ctrl_wr, data_wr, unused_hi;
  logic [NBITS-1:0] tx_hold, tx_shift, rx_shift, rx_byte;
  logic [3:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [31:0] ctrl;
  tx_state_t tx_state;
  rx_state_t rx_state;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (.Clk(Clk), .Rst(Rst), .tick(tick));

  assign ctrl_wr   = wr_i && !reg_sel_i;
  assign data_wr   = wr_i && reg_sel_i;
  assign unused_hi = ^data_i[31:8];

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge Clk)
    loopback <= Rst ? 1'b0 : (ctrl_wr ? data_i[CTRL_LOOPBACK] : loopback);
`else
  assign loopback = 1'b0;
`endif

  // Synchronizer resets to the idle line level so a fresh enable never sees a false start
  always_ff @(posedge Clk) begin
    rx_s1 <= Rst ? 1'b1 : Rx;
    rx_s2 <= Rst ? 1'b1 : rx_s1;
  end
  assign rx_in = loopback ? Tx : rx_s2;

  // Host write to DATA comes after the FSM so a same-cycle write re-arms TX_PEND
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_state <= TX_IDLE;
      Tx       <= 1'b1;
      tx_pend  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_hold  <= '0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      if (tick) begin
        tx_cnt <= tx_cnt + 4'd1;
        case (tx_state)
          TX_IDLE: if (en && tx_pend) begin
            tx_state <= TX_START;
            tx_shift <= tx_hold;
            tx_pend  <= 1'b0;
            tx_busy  <= 1'b1;
            Tx       <= 1'b0;
            tx_cnt   <= '0;
          end
          TX_START: if (tx_cnt == LAST_TICK) begin
            tx_state <= TX_DATA;
            Tx       <= tx_shift[0];
            tx_bit   <= '0;
          end
          TX_DATA: if (tx_cnt == LAST_TICK) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
            tx_state <= (tx_bit == LAST_BIT) ? TX_STOP : TX_DATA;
            Tx       <= (tx_bit == LAST_BIT) ? 1'b1 : tx_shift[1];
          end
          TX_STOP: if (tx_cnt == LAST_TICK) begin
            tx_state <= TX_IDLE;
            tx_busy  <= 1'b0;
          end
        endcase
      end
      if (data_wr) begin
        tx_hold <= data_i[NBITS-1:0];
        tx_pend <= 1'b1;
      end
    end
  end

  // W1C first, hardware sets afterwards so a simultaneous set wins
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_state  <= RX_IDLE;
      en        <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
    end else begin
      if (ctrl_wr) begin
        en <= data_i[CTRL_EN];
        if (data_i[CTRL_RX_VALID])  rx_valid  <= 1'b0;
        if (data_i[CTRL_FRAME_ERR]) frame_err <= 1'b0;
        if (data_i[CTRL_OVERRUN])   overrun   <= 1'b0;
      end
      if (!en)
        rx_state <= RX_IDLE;
      else if (tick) begin
        rx_cnt <= rx_cnt + 4'd1;
        case (rx_state)
          RX_IDLE: if (!rx_in) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
          RX_START: if (rx_cnt == MID_TICK) begin
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
            rx_cnt   <= '0;
            rx_bit   <= '0;
          end
          RX_DATA: if (rx_cnt == LAST_TICK) begin
            rx_shift <= {rx_in, rx_shift[NBITS-1:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_state <= (rx_bit == LAST_BIT) ? RX_STOP : RX_DATA;
          end
          RX_STOP: if (rx_cnt == LAST_TICK) begin
            rx_state <= RX_IDLE;
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid) overrun   <= 1'b1;
            if (!rx_in)   frame_err <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    ctrl                 = '0;
    ctrl[CTRL_EN]        = en;
    ctrl[CTRL_TX_PEND]   = tx_pend;
    ctrl[CTRL_TX_BUSY]   = tx_busy;
    ctrl[CTRL_RX_VALID]  = rx_valid;
    ctrl[CTRL_LOOPBACK]  = loopback;
    ctrl[CTRL_FRAME_ERR] = frame_err;
    ctrl[CTRL_OVERRUN]   = overrun;
  end

  assign data_o = reg_sel_i ? {{(32-NBITS){1'b0}}, rx_byte} : ctrl;
endmodule

// File: tb/tb_uart_reg_core.sv
// tb_uart_reg_core: directed self-checking bench for uart_reg_core at BAUD_DIV=2 (32 cycles per bit)
module tb_uart_reg_core;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Rx = 1'b1;
  logic        Tx;
  logic        reg_sel_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  int errors = 0;
  int checks = 0;

  uart_reg_core #(.BAUD_DIV(16'd2), .NBITS(8)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Tx(Tx),
    .reg_sel_i(reg_sel_i), .wr_i(wr_i), .data_i(data_i), .data_o(data_o)
  );

  always #5 Clk = ~Clk;

  task automatic write_reg(input logic sel, input logic [31:0] d, input int n);
    reg_sel_i = sel;
    data_i    = d;
    wr_i      = 1'b1;
    repeat (n) @(negedge Clk);
    wr_i      = 1'b0;
  endtask

  task automatic read_reg(input logic sel, output logic [31:0] v);
    reg_sel_i = sel;
    #1 v = data_o;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
    Rx = 1'b0;
    repeat (32) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (32) @(negedge Clk);
    end
    Rx = stop;
    repeat (stop_len) @(negedge Clk);
    Rx = 1'b1;
    repeat (40) @(negedge Clk);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Tx); end
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 00000000", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", v); end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_tx;
    logic [31:0] v;
    logic [9:0] frame;
    int n;
    frame = 10'b1101001010;
    write_reg(1'b1, 32'hA5A5A5A5, 10);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL tx_pend: got %h want 00000002", v); end
    write_reg(1'b0, 32'h1, 1);
    n = 0;
    while (Tx !== 1'b0 && n < 20) begin @(negedge Clk); n++; end
    checks++;
    if (Tx !== 1'b0) begin errors++; $display("FAIL tx_start_timeout: got Tx=%b want 0 within 20 cycles", Tx); end
    repeat (16) @(negedge Clk);
    checks++;
    if (Tx !== frame[0]) begin errors++; $display("FAIL tx_bit0: got %b want %b", Tx, frame[0]); end
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL tx_busy: got %h want 00000005", v); end
    for (int i = 1; i < 10; i++) begin
      repeat (32) @(negedge Clk);
      checks++;
      if (Tx !== frame[i]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", i, Tx, frame[i]); end
    end
    repeat (24) @(negedge Clk);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL tx_done_ctrl: got %h want 00000001", v); end
  endtask

  task automatic test_rx;
    logic [31:0] v;
    send_byte(8'h3C, 1'b1, 32);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL rx_ctrl: got %h want 00000009", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h3C) begin errors++; $display("FAIL rx_data: got %h want 0000003c", v); end
  endtask

  task automatic test_errors;
    logic [31:0] v;
    send_byte(8'h81, 1'b1, 32);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h49) begin errors++; $display("FAIL overrun_ctrl: got %h want 00000049", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h81) begin errors++; $display("FAIL overrun_data: got %h want 00000081", v); end
    send_byte(8'h42, 1'b0, 24);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h69) begin errors++; $display("FAIL frame_err_ctrl: got %h want 00000069", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h42) begin errors++; $display("FAIL frame_err_data: got %h want 00000042", v); end
    write_reg(1'b0, 32'h69, 1);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL w1c_ctrl: got %h want 00000001", v); end
  endtask

  task automatic test_glitch_enable;
    logic [31:0] v;
    Rx = 1'b0;
    repeat (2) @(negedge Clk);
    Rx = 1'b1;
    repeat (60) @(negedge Clk);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL glitch_ctrl: got %h want 00000001", v); end
    fork
      send_byte(8'h55, 1'b1, 32);
      begin
        repeat (100) @(negedge Clk);
        write_reg(1'b0, 32'h0, 1);
      end
    join
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL en_abort_ctrl: got %h want 00000000", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h42) begin errors++; $display("FAIL en_abort_data: got %h want 00000042", v); end
    write_reg(1'b0, 32'h1, 1);
    repeat (40) @(negedge Clk);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL reenable_ctrl: got %h want 00000001", v); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] v;
    int n;
    write_reg(1'b1, 32'h0, 1);
    n = 0;
    while (Tx !== 1'b0 && n < 20) begin @(negedge Clk); n++; end
    checks++;
    if (Tx !== 1'b0) begin errors++; $display("FAIL midframe_start_timeout: got Tx=%b want 0", Tx); end
    repeat (40) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b want 1", Tx); end
    Rst = 1'b0;
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL midframe_reset_ctrl: got %h want 00000000", v); end
    @(negedge Clk);
  endtask

  task automatic test_loopback;
    logic [31:0] v;
    int n;
    Rx = 1'b1;
`ifdef UART_LOOPBACK_EN
    write_reg(1'b0, 32'h11, 1);
    write_reg(1'b1, 32'h5A, 1);
    n = 0;
    reg_sel_i = 1'b0;
    while (data_o[3] !== 1'b1 && n < 500) begin @(negedge Clk); n++; end
    repeat (20) @(negedge Clk);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h19) begin errors++; $display("FAIL loopback_ctrl: got %h want 00000019", v); end
    read_reg(1'b1, v);
    checks++;
    if (v !== 32'h5A) begin errors++; $display("FAIL loopback_data: got %h want 0000005a", v); end
`else
    write_reg(1'b0, 32'h11, 1);
    read_reg(1'b0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL loopback_disabled_ctrl: got %h want 00000001", v); end
    n = 0;
`endif
  endtask

  initial begin
    @(negedge Clk);
    test_reset;
    test_tx;
    test_rx;
    test_errors;
    test_glitch_enable;
    test_reset_midframe;
    test_loopback;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
